// File: rtl/order_book_pkg.sv
// order_book_pkg
//   Shared types for the order path (parser and order book store).
//   Holds the parsed-order object layout, message type and result code
//   encodings, field widths, and a key-compare helper.
package order_book_pkg;

  localparam int MSG_TYPE_W = 2;
  localparam int STOCK_ID_W = 32;
  localparam int ORDER_ID_W = 32;
  localparam int QTY_W      = 32;
  localparam int PRICE_W    = 64;
  localparam int EV_CODE_W  = 3;
  localparam int OBJ_W      = MSG_TYPE_W + STOCK_ID_W + ORDER_ID_W + QTY_W + PRICE_W;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_ADD  = 2'b00,
    MSG_DEL  = 2'b01,
    MSG_EXEC = 2'b10,
    MSG_RSVD = 2'b11
  } msg_type_e;

  typedef enum logic [EV_CODE_W-1:0] {
    EV_ADD_OK       = 3'd0,
    EV_DEL_OK       = 3'd1,
    EV_EXEC_PARTIAL = 3'd2,
    EV_EXEC_FILLED  = 3'd3,
    EV_ERR_FULL     = 3'd4,
    EV_ERR_NOT_FOUND= 3'd5,
    EV_ERR_DUP      = 3'd6,
    EV_ERR_BADTYPE  = 3'd7
  } ev_code_e;

  // Bit layout: {msg_type[161:160], stock_id[159:128], order_id[127:96],
  //              quantity[95:64], price[63:0]}
  typedef struct packed {
    msg_type_e               msg_type;
    logic [STOCK_ID_W-1:0]   stock_id;
    logic [ORDER_ID_W-1:0]   order_id;
    logic [QTY_W-1:0]        quantity;
    logic [PRICE_W-1:0]      price;
  } order_obj_t;

  // An order is identified by the full (stock_id, order_id) pair.
  function automatic logic key_match(
    input logic [STOCK_ID_W-1:0] a_stock,
    input logic [ORDER_ID_W-1:0] a_order,
    input logic [STOCK_ID_W-1:0] b_stock,
    input logic [ORDER_ID_W-1:0] b_order
  );
    return (a_stock == b_stock) && (a_order == b_order);
  endfunction

endpackage

// File: rtl/order_table.sv
// order_table
//   Resting-order storage: DEPTH entries of {valid, stock_id, order_id, qty,
//   price}. One combinational indexed read port and one write port.
//   Only valid bits and the occupancy counter are reset.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   rd_idx / rd_*        read index and entry fields at that index
//   wr_en, wr_idx        write strobe and target entry
//   wr_valid             new valid bit (0 removes the entry)
//   wr_*                 new data fields, written only when wr_valid = 1
//   occupancy, full      registered valid-entry count and full flag
module order_table
  import order_book_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [STOCK_ID_W-1:0] rd_stock_id,
  output logic [ORDER_ID_W-1:0] rd_order_id,
  output logic [QTY_W-1:0]      rd_qty,
  output logic [PRICE_W-1:0]    rd_price,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_valid,
  input  logic [STOCK_ID_W-1:0] wr_stock_id,
  input  logic [ORDER_ID_W-1:0] wr_order_id,
  input  logic [QTY_W-1:0]      wr_qty,
  input  logic [PRICE_W-1:0]    wr_price,
  output logic [IDX_W:0]        occupancy,
  output logic                  full
);

  logic [DEPTH-1:0]      valid_r;
  logic [STOCK_ID_W-1:0] stock_id_r [DEPTH];
  logic [ORDER_ID_W-1:0] order_id_r [DEPTH];
  logic [QTY_W-1:0]      qty_r      [DEPTH];
  logic [PRICE_W-1:0]    price_r    [DEPTH];
  logic [IDX_W:0]        occupancy_r;
  logic                  full_r;
  logic [IDX_W:0]        occ_nxt_s;

  assign rd_valid    = valid_r[rd_idx];
  assign rd_stock_id = stock_id_r[rd_idx];
  assign rd_order_id = order_id_r[rd_idx];
  assign rd_qty      = qty_r[rd_idx];
  assign rd_price    = price_r[rd_idx];
  assign occupancy   = occupancy_r;
  assign full        = full_r;

  // Next occupancy: count only real valid-bit transitions.
  always_comb begin
    occ_nxt_s = occupancy_r;
    if (wr_en && wr_valid && !valid_r[wr_idx]) begin
      occ_nxt_s = occupancy_r + (IDX_W+1)'(1);
    end else if (wr_en && !wr_valid && valid_r[wr_idx]) begin
      occ_nxt_s = occupancy_r - (IDX_W+1)'(1);
    end else begin
      occ_nxt_s = occupancy_r;
    end
  end

  // Valid bits, occupancy and full flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_r     <= '0;
      occupancy_r <= '0;
      full_r      <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_r[wr_idx] <= wr_valid;
      end
      occupancy_r <= occ_nxt_s;
      full_r      <= (occ_nxt_s == (IDX_W+1)'(DEPTH));
    end
  end

  // Entry data fields; left untouched on removal since they are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en && wr_valid) begin
      stock_id_r[wr_idx] <= wr_stock_id;
      order_id_r[wr_idx] <= wr_order_id;
      qty_r[wr_idx]      <= wr_qty;
      price_r[wr_idx]    <= wr_price;
    end
  end

endmodule

// File: rtl/order_book_store.sv
// order_book_store
//   Consumes parsed order objects (add / delete / execute), keeps a DEPTH-entry
//   resting-order table and emits one result event per object. Lookup is a
//   sequential scan of one entry per cycle, so every valid object takes a fixed
//   DEPTH+2 cycles from accept to event.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   in_valid/in_ready/in_object parsed order object handshake (162 bits)
//   ev_valid/ev_ready           result event handshake
//   ev_code, ev_order_id,       result code, order id, remaining quantity and
//   ev_qty, ev_price            entry price of the processed object
//   occupancy, full             number of valid entries, table-full flag
module order_book_store
  import order_book_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OBJ_W-1:0]      in_object,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [EV_CODE_W-1:0]  ev_code,
  output logic [ORDER_ID_W-1:0] ev_order_id,
  output logic [QTY_W-1:0]      ev_qty,
  output logic [PRICE_W-1:0]    ev_price,
  output logic [IDX_W:0]        occupancy,
  output logic                  full
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  logic [1:0]            state_r, state_nxt_s;
  logic                  in_ready_r;
  order_obj_t            in_obj_s, obj_r;
  logic                  accept_s;
  logic [IDX_W-1:0]      idx_r;
  logic                  found_r, free_found_r;
  logic [IDX_W-1:0]      match_idx_r, free_idx_r;
  logic [QTY_W-1:0]      match_qty_r;
  logic [PRICE_W-1:0]    match_price_r;
  ev_code_e              res_code_r, upd_code_s;
  logic [QTY_W-1:0]      res_qty_r, upd_qty_s;
  logic [PRICE_W-1:0]    res_price_r, upd_price_s;
  logic                  ev_valid_r;
  logic [EV_CODE_W-1:0]  ev_code_r;
  logic [ORDER_ID_W-1:0] ev_order_id_r;
  logic [QTY_W-1:0]      ev_qty_r;
  logic [PRICE_W-1:0]    ev_price_r;

  logic                  rd_valid_s;
  logic [STOCK_ID_W-1:0] rd_stock_id_s;
  logic [ORDER_ID_W-1:0] rd_order_id_s;
  logic [QTY_W-1:0]      rd_qty_s;
  logic [PRICE_W-1:0]    rd_price_s;
  logic                  wr_en_s, wr_valid_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [QTY_W-1:0]      wr_qty_s;
  logic [PRICE_W-1:0]    wr_price_s;

  assign in_obj_s    = in_object;
  assign accept_s    = in_valid && in_ready_r;
  assign in_ready    = in_ready_r;
  assign ev_valid    = ev_valid_r;
  assign ev_code     = ev_code_r;
  assign ev_order_id = ev_order_id_r;
  assign ev_qty      = ev_qty_r;
  assign ev_price    = ev_price_r;

  order_table #(.DEPTH(DEPTH)) u_table (
    .clk         (clk),
    .resetn      (resetn),
    .rd_idx      (idx_r),
    .rd_valid    (rd_valid_s),
    .rd_stock_id (rd_stock_id_s),
    .rd_order_id (rd_order_id_s),
    .rd_qty      (rd_qty_s),
    .rd_price    (rd_price_s),
    .wr_en       (wr_en_s),
    .wr_idx      (wr_idx_s),
    .wr_valid    (wr_valid_s),
    .wr_stock_id (obj_r.stock_id),
    .wr_order_id (obj_r.order_id),
    .wr_qty      (wr_qty_s),
    .wr_price    (wr_price_s),
    .occupancy   (occupancy),
    .full        (full)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (in_obj_s.msg_type == MSG_RSVD) ? ST_REPORT : ST_SEARCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_UPDATE: state_nxt_s = ST_REPORT;
      ST_REPORT: begin
        if (ev_valid_r && ev_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Table update and result selection for the single UPDATE cycle.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_valid_s  = 1'b0;
    wr_idx_s    = match_idx_r;
    wr_qty_s    = match_qty_r;
    wr_price_s  = match_price_r;
    upd_code_s  = EV_ERR_NOT_FOUND;
    upd_qty_s   = '0;
    upd_price_s = '0;
    if (state_r == ST_UPDATE) begin
      case (obj_r.msg_type)
        MSG_ADD: begin
          if (found_r) begin
            upd_code_s = EV_ERR_DUP;
          end else if (!free_found_r) begin
            upd_code_s = EV_ERR_FULL;
          end else begin
            wr_en_s     = 1'b1;
            wr_valid_s  = 1'b1;
            wr_idx_s    = free_idx_r;
            wr_qty_s    = obj_r.quantity;
            wr_price_s  = obj_r.price;
            upd_code_s  = EV_ADD_OK;
            upd_qty_s   = obj_r.quantity;
            upd_price_s = obj_r.price;
          end
        end
        MSG_DEL: begin
          if (found_r) begin
            wr_en_s     = 1'b1;
            upd_code_s  = EV_DEL_OK;
            upd_price_s = match_price_r;
          end else begin
            upd_code_s = EV_ERR_NOT_FOUND;
          end
        end
        MSG_EXEC: begin
          if (!found_r) begin
            upd_code_s = EV_ERR_NOT_FOUND;
          end else if (obj_r.quantity >= match_qty_r) begin
            // Overfill clamps to a full fill, so the subtraction below never wraps.
            wr_en_s     = 1'b1;
            upd_code_s  = EV_EXEC_FILLED;
            upd_price_s = match_price_r;
          end else begin
            wr_en_s     = 1'b1;
            wr_valid_s  = 1'b1;
            wr_qty_s    = match_qty_r - obj_r.quantity;
            upd_code_s  = EV_EXEC_PARTIAL;
            upd_qty_s   = match_qty_r - obj_r.quantity;
            upd_price_s = match_price_r;
          end
        end
        default: upd_code_s = EV_ERR_BADTYPE;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FSM state, scan bookkeeping and event output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      in_ready_r    <= 1'b0;
      obj_r         <= '0;
      idx_r         <= '0;
      found_r       <= 1'b0;
      free_found_r  <= 1'b0;
      match_idx_r   <= '0;
      free_idx_r    <= '0;
      match_qty_r   <= '0;
      match_price_r <= '0;
      res_code_r    <= EV_ADD_OK;
      res_qty_r     <= '0;
      res_price_r   <= '0;
      ev_valid_r    <= 1'b0;
      ev_code_r     <= '0;
      ev_order_id_r <= '0;
      ev_qty_r      <= '0;
      ev_price_r    <= '0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            obj_r        <= in_obj_s;
            idx_r        <= '0;
            found_r      <= 1'b0;
            free_found_r <= 1'b0;
            // Reserved types skip the scan and report straight away.
            res_code_r   <= EV_ERR_BADTYPE;
            res_qty_r    <= '0;
            res_price_r  <= '0;
          end
        end
        ST_SEARCH: begin
          if (rd_valid_s && key_match(rd_stock_id_s, rd_order_id_s,
                                      obj_r.stock_id, obj_r.order_id)) begin
            found_r       <= 1'b1;
            match_idx_r   <= idx_r;
            match_qty_r   <= rd_qty_s;
            match_price_r <= rd_price_s;
          end
          if (!rd_valid_s && !free_found_r) begin
            free_found_r <= 1'b1;
            free_idx_r   <= idx_r;
          end
          idx_r <= idx_r + IDX_W'(1);
        end
        ST_UPDATE: begin
          res_code_r  <= upd_code_s;
          res_qty_r   <= upd_qty_s;
          res_price_r <= upd_price_s;
        end
        ST_REPORT: begin
          if (!ev_valid_r) begin
            ev_valid_r    <= 1'b1;
            ev_code_r     <= res_code_r;
            ev_order_id_r <= obj_r.order_id;
            ev_qty_r      <= res_qty_r;
            ev_price_r    <= res_price_r;
          end else if (ev_ready) begin
            ev_valid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_book_store.sv
// tb_order_book_store
//   Directed-vector bench for order_book_store with hand-computed expectations.
module tb_order_book_store;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam logic [31:0] STK   = 32'h41424344;
  localparam logic [31:0] STK_B = 32'h51525354;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [161:0] in_object = '0;
  logic         ev_valid;
  logic         ev_ready = 1'b0;
  logic [2:0]   ev_code;
  logic [31:0]  ev_order_id;
  logic [31:0]  ev_qty;
  logic [63:0]  ev_price;
  logic [IDX_W:0] occupancy;
  logic         full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  order_book_store #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_object   (in_object),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_order_id (ev_order_id),
    .ev_qty      (ev_qty),
    .ev_price    (ev_price),
    .occupancy   (occupancy),
    .full        (full)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one object, wait for its event, check latency and fields,
  // optionally hold ev_ready low for 'hold' cycles, then complete the handshake.
  task automatic do_op(input logic [1:0] t, input logic [31:0] stk, input logic [31:0] id,
                       input logic [31:0] qty, input logic [63:0] pr,
                       input logic [2:0] ecode, input logic [31:0] eqty,
                       input logic [63:0] epr, input int hold, input string tag);
    int lat;
    check_val({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_object = {t, stk, id, qty, pr};
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat = 0;
    while (!ev_valid && lat < DEPTH + 10) begin
      tick();
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), (t == 2'b11) ? 64'd1 : 64'(DEPTH + 2));
    check_val({tag, " code"}, 64'(ev_code), 64'(ecode));
    check_val({tag, " id"}, 64'(ev_order_id), 64'(id));
    check_val({tag, " qty"}, 64'(ev_qty), 64'(eqty));
    check_val({tag, " price"}, ev_price, epr);
    for (int k = 0; k < hold; k++) begin
      tick();
      check_val({tag, " hold valid"}, 64'(ev_valid), 64'd1);
      check_val({tag, " hold code"}, 64'(ev_code), 64'(ecode));
      check_val({tag, " hold qty"}, 64'(ev_qty), 64'(eqty));
      check_val({tag, " hold price"}, ev_price, epr);
      check_val({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check_val({tag, " ev drop"}, 64'(ev_valid), 64'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check_val("rst in_ready", 64'(in_ready), 64'd0);
    check_val("rst ev_valid", 64'(ev_valid), 64'd0);
    check_val("rst ev_code", 64'(ev_code), 64'd0);
    check_val("rst ev_id", 64'(ev_order_id), 64'd0);
    check_val("rst ev_qty", 64'(ev_qty), 64'd0);
    check_val("rst ev_price", ev_price, 64'd0);
    check_val("rst occupancy", 64'(occupancy), 64'd0);
    check_val("rst full", 64'(full), 64'd0);
    resetn = 1'b1;
    tick();
    check_val("post-rst in_ready", 64'(in_ready), 64'd1);

    // Add, partial execute, overfilling execute
    do_op(2'b00, STK, 32'd1, 32'd100, 64'd5000, 3'd0, 32'd100, 64'd5000, 0, "add1");
    check_val("occ after add1", 64'(occupancy), 64'd1);
    do_op(2'b10, STK, 32'd1, 32'd30, 64'd0, 3'd2, 32'd70, 64'd5000, 0, "exec30");
    check_val("occ after exec30", 64'(occupancy), 64'd1);
    do_op(2'b10, STK, 32'd1, 32'd90, 64'd0, 3'd3, 32'd0, 64'd5000, 0, "exec90");
    check_val("occ after fill", 64'(occupancy), 64'd0);

    // Fill the table
    for (int i = 1; i <= DEPTH; i++) begin
      do_op(2'b00, STK, 32'(i), 32'(10 * i), 64'(100 + i), 3'd0, 32'(10 * i), 64'(100 + i), 0, "fill");
    end
    check_val("occ full", 64'(occupancy), 64'd16);
    check_val("full flag", 64'(full), 64'd1);
    do_op(2'b00, STK, 32'd17, 32'd170, 64'd117, 3'd4, 32'd0, 64'd0, 0, "add17 full");
    check_val("occ after err_full", 64'(occupancy), 64'd16);
    check_val("full after err_full", 64'(full), 64'd1);

    // Free index 4 and refill it
    do_op(2'b01, STK, 32'd5, 32'd0, 64'd0, 3'd1, 32'd0, 64'd105, 0, "del5");
    check_val("occ after del5", 64'(occupancy), 64'd15);
    check_val("full after del5", 64'(full), 64'd0);
    do_op(2'b00, STK, 32'd17, 32'd170, 64'd117, 3'd0, 32'd170, 64'd117, 0, "add17");
    check_val("add17 slot", 64'(dut.u_table.order_id_r[4]), 64'd17);
    check_val("full after add17", 64'(full), 64'd1);

    // Empty the table again
    for (int i = 1; i <= DEPTH; i++) begin
      if (i != 5) begin
        do_op(2'b01, STK, 32'(i), 32'd0, 64'd0, 3'd1, 32'd0, 64'(100 + i), 0, "drain");
      end
    end
    do_op(2'b01, STK, 32'd17, 32'd0, 64'd0, 3'd1, 32'd0, 64'd117, 0, "drain17");
    check_val("occ drained", 64'(occupancy), 64'd0);

    // Duplicate, not-found, stock mismatch, exact fill, zero-qty add
    do_op(2'b00, STK, 32'd7, 32'd7, 64'd77, 3'd0, 32'd7, 64'd77, 0, "add7");
    do_op(2'b00, STK, 32'd7, 32'd9, 64'd99, 3'd6, 32'd0, 64'd0, 0, "add7 dup");
    check_val("occ after dup", 64'(occupancy), 64'd1);
    do_op(2'b01, STK, 32'd99, 32'd0, 64'd0, 3'd5, 32'd0, 64'd0, 0, "del99");
    do_op(2'b10, STK_B, 32'd7, 32'd1, 64'd0, 3'd5, 32'd0, 64'd0, 0, "exec7 other stk");
    do_op(2'b10, STK, 32'd7, 32'd7, 64'd0, 3'd3, 32'd0, 64'd77, 0, "exec7 exact");
    do_op(2'b00, STK, 32'd8, 32'd0, 64'd88, 3'd0, 32'd0, 64'd88, 0, "add8 qty0");
    do_op(2'b01, STK, 32'd8, 32'd0, 64'd0, 3'd1, 32'd0, 64'd88, 0, "del8");

    // Reserved type with back-pressure
    do_op(2'b11, STK, 32'd33, 32'd5, 64'd55, 3'd7, 32'd0, 64'd0, 5, "badtype");
    check_val("occ after badtype", 64'(occupancy), 64'd0);

    // Reset in the middle of a scan
    do_op(2'b00, STK, 32'd50, 32'd5, 64'd500, 3'd0, 32'd5, 64'd500, 0, "add50");
    in_object = {2'b00, STK, 32'd51, 32'd6, 64'd600};
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    check_val("midrst in_ready low", 64'(in_ready), 64'd0);
    resetn = 1'b1;
    tick();
    check_val("midrst in_ready", 64'(in_ready), 64'd1);
    check_val("midrst occupancy", 64'(occupancy), 64'd0);
    check_val("midrst full", 64'(full), 64'd0);
    seen = 0;
    repeat (DEPTH + 4) begin
      tick();
      if (ev_valid) seen = 1;
    end
    check_val("midrst no event", 64'(seen), 64'd0);
    do_op(2'b01, STK, 32'd50, 32'd0, 64'd0, 3'd5, 32'd0, 64'd0, 0, "del50 after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
